// File: rtl/fetch_decode.sv
// Instruction front end: one Wishbone classic-pipelined read per enable, followed by a
// registered decode of the fetched word into opcode, extra, register indices and immediate.
module fetch_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic [31:0] i_pc,
   output logic [31:0] o_wb_addr,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_instruction,
   output logic        o_fetch_done,
   output logic [3:0]  o_opcode,
   output logic [3:0]  o_extra,
   output logic [3:0]  o_operandA,
   output logic [3:0]  o_operandB,
   output logic [15:0] o_immediate,
   output logic        o_completed
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        capture;
   logic [31:0] addr_q;
   logic [31:0] instr_q;
   logic [3:0]  opcode_q, extra_q, operand_a_q, operand_b_q;
   logic [15:0] immediate_q;
   logic        completed_q;

   // An ack is only meaningful once the request has been accepted (stall low).
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_enable) state_d = REQ;
         end
         REQ: begin
            if (!i_wb_stall) begin
               if (i_wb_ack) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (i_wb_ack) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= 32'h0;
         instr_q     <= 32'h0;
         opcode_q    <= 4'h0;
         extra_q     <= 4'h0;
         operand_a_q <= 4'h0;
         operand_b_q <= 4'h0;
         immediate_q <= 16'h0;
         completed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         completed_q <= (state_q == DONE);
         if (state_q == IDLE && i_enable) addr_q <= i_pc;
         if (capture) instr_q <= i_wb_data;
         if (state_q == DONE) begin
            opcode_q    <= instr_q[31:28];
            extra_q     <= instr_q[27:24];
            operand_a_q <= instr_q[23:20];
            operand_b_q <= instr_q[19:16];
            immediate_q <= instr_q[15:0];
         end
      end
   end

   assign o_wb_addr     = addr_q;
   assign o_wb_cyc      = (state_q == REQ) || (state_q == WAIT);
   assign o_wb_stb      = (state_q == REQ);
   assign o_wb_we       = 1'b0;
   assign o_instruction = instr_q;
   assign o_fetch_done  = (state_q == DONE);
   assign o_opcode      = opcode_q;
   assign o_extra       = extra_q;
   assign o_operandA    = operand_a_q;
   assign o_operandB    = operand_b_q;
   assign o_immediate   = immediate_q;
   assign o_completed   = completed_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: table of fetch vectors with a scoreboard queue,
// plus hand-written reset and back-to-back sequences. Inputs change and outputs are sampled
// on the falling edge.
module tb_fetch_decode;

   logic        clk;
   logic        reset;
   logic        i_enable;
   logic [31:0] i_pc;
   logic [31:0] o_wb_addr;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic        i_wb_ack, i_wb_stall;
   logic [31:0] i_wb_data;
   logic [31:0] o_instruction;
   logic        o_fetch_done;
   logic [3:0]  o_opcode, o_extra, o_operandA, o_operandB;
   logic [15:0] o_immediate;
   logic        o_completed;

   fetch_decode dut (
      .clk           (clk),
      .reset         (reset),
      .i_enable      (i_enable),
      .i_pc          (i_pc),
      .o_wb_addr     (o_wb_addr),
      .o_wb_cyc      (o_wb_cyc),
      .o_wb_stb      (o_wb_stb),
      .o_wb_we       (o_wb_we),
      .i_wb_ack      (i_wb_ack),
      .i_wb_stall    (i_wb_stall),
      .i_wb_data     (i_wb_data),
      .o_instruction (o_instruction),
      .o_fetch_done  (o_fetch_done),
      .o_opcode      (o_opcode),
      .o_extra       (o_extra),
      .o_operandA    (o_operandA),
      .o_operandB    (o_operandB),
      .o_immediate   (o_immediate),
      .o_completed   (o_completed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          stalls;
      int          ack_delay;
      bit          spurious_en;
      bit          b2b_next;
      logic [3:0]  op;
      logic [3:0]  ext;
      logic [3:0]  opa;
      logic [3:0]  opb;
      logic [15:0] imm;
   } vec_t;

   vec_t vecs[5];
   vec_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   n_comp = 0;

   // Independent event counters for catching spurious strobes anywhere in the run.
   always @(negedge clk) begin
      if (o_fetch_done === 1'b1) n_done++;
      if (o_completed === 1'b1) n_comp++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " addr"}, o_wb_addr, 32'h0);
      chk({tag, " cyc"}, {31'h0, o_wb_cyc}, 32'h0);
      chk({tag, " stb"}, {31'h0, o_wb_stb}, 32'h0);
      chk({tag, " we"}, {31'h0, o_wb_we}, 32'h0);
      chk({tag, " instr"}, o_instruction, 32'h0);
      chk({tag, " fdone"}, {31'h0, o_fetch_done}, 32'h0);
      chk({tag, " fields"}, {o_opcode, o_extra, o_operandA, o_operandB, o_immediate}, 32'h0);
      chk({tag, " compl"}, {31'h0, o_completed}, 32'h0);
   endtask

   // Called at a falling edge of an IDLE cycle; returns at the falling edge of the
   // o_completed cycle so a caller can launch the next fetch back-to-back.
   task automatic do_fetch(input vec_t v);
      vec_t exp;
      i_enable = 1'b1;
      i_pc     = v.pc;
      sb_q.push_back(v);
      @(negedge clk);
      i_enable = 1'b0;
      i_pc     = ~v.pc;
      for (int s = 0; s < v.stalls; s++) begin
         chk("stall stb", {31'h0, o_wb_stb}, 32'h1);
         chk("stall addr", o_wb_addr, v.pc);
         i_wb_stall = 1'b1;
         @(negedge clk);
      end
      chk("req cyc", {31'h0, o_wb_cyc}, 32'h1);
      chk("req stb", {31'h0, o_wb_stb}, 32'h1);
      chk("req addr", o_wb_addr, v.pc);
      i_wb_stall = 1'b0;
      if (v.ack_delay == 0) begin
         i_wb_ack  = 1'b1;
         i_wb_data = v.data;
      end
      @(negedge clk);
      i_wb_ack = 1'b0;
      for (int d = 1; d <= v.ack_delay; d++) begin
         chk("wait cyc", {31'h0, o_wb_cyc}, 32'h1);
         chk("wait stb", {31'h0, o_wb_stb}, 32'h0);
         i_enable = v.spurious_en;
         i_pc     = 32'hDEAD_0000;
         if (d == v.ack_delay) begin
            i_wb_ack  = 1'b1;
            i_wb_data = v.data;
         end
         @(negedge clk);
         i_wb_ack = 1'b0;
         i_enable = 1'b0;
      end
      chk("done fdone", {31'h0, o_fetch_done}, 32'h1);
      chk("done instr", o_instruction, v.data);
      chk("done cyc", {31'h0, o_wb_cyc}, 32'h0);
      chk("done compl", {31'h0, o_completed}, 32'h0);
      i_wb_data = $urandom;
      @(negedge clk);
      chk("compl", {31'h0, o_completed}, 32'h1);
      chk("compl fdone", {31'h0, o_fetch_done}, 32'h0);
      chk("compl stb", {31'h0, o_wb_stb}, 32'h0);
      if (sb_q.size() == 0) begin
         chk("scoreboard empty", 32'h1, 32'h0);
      end else begin
         exp = sb_q.pop_front();
         chk("opcode", {28'h0, o_opcode}, {28'h0, exp.op});
         chk("extra", {28'h0, o_extra}, {28'h0, exp.ext});
         chk("operandA", {28'h0, o_operandA}, {28'h0, exp.opa});
         chk("operandB", {28'h0, o_operandB}, {28'h0, exp.opb});
         chk("immediate", {16'h0, o_immediate}, {16'h0, exp.imm});
      end
   endtask

   initial begin
      vecs[0] = '{32'hB000_0000, 32'h1A3C_1234, 0, 1, 1'b0, 1'b0, 4'h1, 4'hA, 4'h3, 4'hC, 16'h1234};
      vecs[1] = '{32'h0000_1000, 32'h5F0E_8001, 3, 1, 1'b0, 1'b0, 4'h5, 4'hF, 4'h0, 4'hE, 16'h8001};
      vecs[2] = '{32'h0000_2004, 32'hC7D2_9ABC, 0, 5, 1'b1, 1'b0, 4'hC, 4'h7, 4'hD, 4'h2, 16'h9ABC};
      vecs[3] = '{32'h0000_300C, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
      vecs[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF};

      reset      = 1'b0;
      i_enable   = 1'b0;
      i_pc       = 32'h0;
      i_wb_ack   = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_data  = 32'h0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         do_fetch(vecs[i]);
         if (!vecs[i].b2b_next) begin
            @(negedge clk);
            chk("post compl", {31'h0, o_completed}, 32'h0);
            @(negedge clk);
         end
      end

      // Reset while in WAIT, then a stray ack that must be ignored.
      i_enable = 1'b1;
      i_pc     = 32'h0000_0040;
      @(negedge clk);
      i_enable = 1'b0;
      @(negedge clk);
      chk("rst wait cyc", {31'h0, o_wb_cyc}, 32'h1);
      chk("rst wait stb", {31'h0, o_wb_stb}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("midreset");
      reset     = 1'b1;
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h7777_7777;
      @(negedge clk);
      i_wb_ack = 1'b0;
      chk("stray cyc", {31'h0, o_wb_cyc}, 32'h0);
      chk("stray fdone", {31'h0, o_fetch_done}, 32'h0);
      @(negedge clk);
      chk("stray fdone2", {31'h0, o_fetch_done}, 32'h0);
      chk("stray instr", o_instruction, 32'h0);
      @(negedge clk);
      chk("stray compl", {31'h0, o_completed}, 32'h0);

      do_fetch(vecs[0]);
      @(negedge clk);
      @(negedge clk);
      chk("total fetch_done", n_done, 32'd6);
      chk("total completed", n_comp, 32'd6);
      chk("scoreboard drained", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction front end of the 32-bit load/store CPU. On a one-cycle enable it reads one 32-bit instruction word at the supplied program counter over a Wishbone classic-pipelined master read port. It then splits the word into opcode, extra, two register indices and a 16-bit immediate, and pulses a completion strobe that starts the execute stage.

## Interface
Parameters:
- none; data, address and instruction widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- i_enable  in  1  start a fetch; sampled only in IDLE.
- i_pc  in  32  instruction address; latched when i_enable is accepted.
- o_wb_addr  out  32  Wishbone address (latched PC).
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe.
- o_wb_we  out  1  write enable; constant 0 (read-only master).
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave stall; the request is not accepted while high.
- i_wb_data  in  32  read data; valid with i_wb_ack.
- o_instruction  out  32  last fetched word; held until the next ack.
- o_fetch_done  out  1  one-cycle pulse: o_instruction updated.
- o_opcode  out  4  instruction[31:28].
- o_extra  out  4  instruction[27:24].
- o_operandA  out  4  instruction[23:20].
- o_operandB  out  4  instruction[19:16].
- o_immediate  out  16  instruction[15:0].
- o_completed  out  1  one-cycle pulse: decode fields valid.

## Operation
- Fetch FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - on i_enable=1, latch i_pc into o_wb_addr and go to REQ;
  - otherwise cyc=stb=0.
- REQ: cyc=1, stb=1.
  - If i_wb_stall=0, the request is accepted: drop stb next cycle and go to WAIT.
  - If i_wb_ack=1 in the same cycle, capture i_wb_data and go to DONE.
  - If stall=1, hold stb and address unchanged.
- WAIT: cyc=1, stb=0.
  - On i_wb_ack=1, register i_wb_data into o_instruction and go to DONE.
- DONE:
  - cyc=0, stb=0, o_fetch_done=1 for this single cycle;
  - return to IDLE.
- Decode stage is registered. In the cycle after o_fetch_done=1 it loads all five fields from o_instruction and drives o_completed=1 for one cycle.
- Decode fields hold their values until the next decode. o_completed is 0 otherwise.
- Field extraction is pure bit slicing: no sign extension and no opcode validation. Unknown opcodes decode normally.
- i_enable outside IDLE is ignored; enables are not queued.
- i_wb_ack outside REQ/WAIT is ignored.
- i_pc changes after acceptance do not affect the in-flight fetch.

## Timing
- Reset (reset=0 at a clock edge): FSM goes to IDLE. All outputs go to 0: o_wb_addr, cyc, stb, we, o_instruction, o_fetch_done, every decode field, o_completed.
- Reset mid-fetch aborts the cycle: cyc and stb are low on the following cycle, and a later ack is ignored.
- With i_enable sampled at edge E:
  - cyc/stb are high from E+1;
  - with no stall, stb is high for exactly one cycle.
- With ack sampled at edge A:
  - o_instruction is valid and o_fetch_done=1 in cycle A+1;
  - decode fields are valid and o_completed=1 in cycle A+2.
- Minimum latency, enable to o_completed: 4 cycles (ack in the same cycle as stb, no stall).
- Back-to-back: a new i_enable is accepted in the cycle where o_completed is high (FSM already in IDLE).

## Test plan
- Basic fetch:
  - stimulus: i_pc=0xb0000000, i_enable pulse; slave acks 1 cycle after stb with data 0x1A3C1234;
  - required: o_wb_addr=0xb0000000, stb high for 1 cycle, o_instruction=0x1A3C1234;
  - decode: opcode=1, extra=A, operandA=3, operandB=C, immediate=0x1234, o_completed single-cycle.
- Stall:
  - stimulus: i_wb_stall=1 for 3 cycles;
  - required: stb and o_wb_addr held for 4 cycles; ack then completes normally, and latency grows by 3.
- Delayed ack: ack 5 cycles after stb acceptance -> cyc stays high through WAIT, stb low; fields correct.
- Ignored enable: i_enable pulses during WAIT -> no second request; exactly one o_completed.
- Reset mid-fetch:
  - stimulus: reset=0 while in WAIT, then a stray ack;
  - required: all outputs 0, no o_fetch_done or o_completed; the next fetch works.
- Back-to-back: two fetches, 0x00000000 then 0xFFFFFFFF -> second fields all ones and immediate=0xFFFF. Each o_completed lasts exactly one cycle.
